// File: rtl/polar_to_rect.sv
// polar_to_rect: converts an unsigned magnitude and a phase into a signed
// I/Q pair using a quarter-wave sine ROM with quadrant folding, followed by
// a four-stage multiply/scale pipeline with a strobe-only streaming interface.
module polar_to_rect #(
  parameter int MAG_BITS      = 17,
  parameter int PHASE_BITS    = 12,
  parameter int SINE_BITS     = 16,
  parameter int LUT_ADDR_BITS = PHASE_BITS - 2,
  parameter int DATA_OUT_BITS = MAG_BITS + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_in_ready,
  input  logic [MAG_BITS-1:0]      mag_in,
  input  logic [PHASE_BITS-1:0]    phase_in,
  output logic [DATA_OUT_BITS-1:0] data_out_1,
  output logic [DATA_OUT_BITS-1:0] data_out_2,
  output logic                     data_out_ready
);

  localparam int  N         = 1 << LUT_ADDR_BITS;
  localparam int  ADDR_BITS = LUT_ADDR_BITS + 1;
  localparam int  PROD_BITS = MAG_BITS + SINE_BITS;
  localparam real PI        = 3.14159265358979323846;

  // Quarter-wave table entry: floor(full_scale * sin(pi/2 * k/N)).
  // The k == N entry is forced to exact full scale so that floating-point
  // rounding of sin(pi/2) can never drop it by one count.
  function automatic logic [SINE_BITS-1:0] sine_entry(input int k);
    real full_scale;
    real angle;
    full_scale = real'((longint'(1) << SINE_BITS) - 1);
    angle      = (PI / 2.0) * real'(k) / real'(N);
    if (k >= N) return {SINE_BITS{1'b1}};
    return SINE_BITS'($rtoi($floor(full_scale * $sin(angle))));
  endfunction

  // Read-only ROM of N+1 entries, fixed at elaboration.
  logic [SINE_BITS-1:0] rom [0:N];
  for (genvar g = 0; g <= N; g++) begin : g_rom
    assign rom[g] = sine_entry(g);
  end

  // Phase decode: top two bits pick the quadrant, the rest index the table.
  logic [1:0]           quadrant;
  logic [ADDR_BITS-1:0] idx_fwd;
  logic [ADDR_BITS-1:0] idx_rev;
  logic [ADDR_BITS-1:0] sin_addr_d;
  logic [ADDR_BITS-1:0] cos_addr_d;
  logic                 sin_neg_d;
  logic                 cos_neg_d;

  assign quadrant = phase_in[PHASE_BITS-1 -: 2];
  assign idx_fwd  = {1'b0, phase_in[LUT_ADDR_BITS-1:0]};
  assign idx_rev  = ADDR_BITS'(N) - idx_fwd;

  // Quadrant folding: choose forward or mirrored table address and sign.
  always_comb begin
    sin_addr_d = idx_fwd;
    cos_addr_d = idx_rev;
    sin_neg_d  = 1'b0;
    cos_neg_d  = 1'b0;
    unique case (quadrant)
      2'd0: begin
        sin_addr_d = idx_fwd;
        cos_addr_d = idx_rev;
      end
      2'd1: begin
        sin_addr_d = idx_rev;
        cos_addr_d = idx_fwd;
        cos_neg_d  = 1'b1;
      end
      2'd2: begin
        sin_addr_d = idx_fwd;
        cos_addr_d = idx_rev;
        sin_neg_d  = 1'b1;
        cos_neg_d  = 1'b1;
      end
      2'd3: begin
        sin_addr_d = idx_rev;
        cos_addr_d = idx_fwd;
        sin_neg_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage 1 state
  logic                 v1;
  logic [MAG_BITS-1:0]  mag_s1;
  logic [ADDR_BITS-1:0] sin_addr_s1;
  logic [ADDR_BITS-1:0] cos_addr_s1;
  logic                 sin_neg_s1;
  logic                 cos_neg_s1;

  // Stage 1: capture magnitude, folded addresses and signs of an accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1          <= 1'b0;
      mag_s1      <= '0;
      sin_addr_s1 <= '0;
      cos_addr_s1 <= '0;
      sin_neg_s1  <= 1'b0;
      cos_neg_s1  <= 1'b0;
    end else begin
      v1 <= data_in_ready;
      if (data_in_ready) begin
        mag_s1      <= mag_in;
        sin_addr_s1 <= sin_addr_d;
        cos_addr_s1 <= cos_addr_d;
        sin_neg_s1  <= sin_neg_d;
        cos_neg_s1  <= cos_neg_d;
      end
    end
  end

  // Stage 2 state
  logic                 v2;
  logic [MAG_BITS-1:0]  mag_s2;
  logic [SINE_BITS-1:0] sin_s2;
  logic [SINE_BITS-1:0] cos_s2;
  logic                 sin_neg_s2;
  logic                 cos_neg_s2;

  // Stage 2: registered table reads, magnitude and signs carried along.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2         <= 1'b0;
      mag_s2     <= '0;
      sin_s2     <= '0;
      cos_s2     <= '0;
      sin_neg_s2 <= 1'b0;
      cos_neg_s2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        mag_s2     <= mag_s1;
        sin_s2     <= rom[sin_addr_s1];
        cos_s2     <= rom[cos_addr_s1];
        sin_neg_s2 <= sin_neg_s1;
        cos_neg_s2 <= cos_neg_s1;
      end
    end
  end

  // Stage 3 state
  logic                 v3;
  logic [PROD_BITS-1:0] prod_sin_s3;
  logic [PROD_BITS-1:0] prod_cos_s3;
  logic                 sin_neg_s3;
  logic                 cos_neg_s3;

  // Stage 3: full-width unsigned products of magnitude and table values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3          <= 1'b0;
      prod_sin_s3 <= '0;
      prod_cos_s3 <= '0;
      sin_neg_s3  <= 1'b0;
      cos_neg_s3  <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        prod_sin_s3 <= PROD_BITS'(mag_s2) * PROD_BITS'(sin_s2);
        prod_cos_s3 <= PROD_BITS'(mag_s2) * PROD_BITS'(cos_s2);
        sin_neg_s3  <= sin_neg_s2;
        cos_neg_s3  <= cos_neg_s2;
      end
    end
  end

  // Scale back by the table full scale (floor), widen by one bit and apply sign.
  // The scaled value is at most 2^MAG_BITS-1, so the negation cannot wrap.
  logic [MAG_BITS-1:0]      scaled_sin;
  logic [MAG_BITS-1:0]      scaled_cos;
  logic [DATA_OUT_BITS-1:0] i_next;
  logic [DATA_OUT_BITS-1:0] q_next;

  always_comb begin
    scaled_sin = MAG_BITS'(prod_sin_s3 >> SINE_BITS);
    scaled_cos = MAG_BITS'(prod_cos_s3 >> SINE_BITS);
    i_next     = DATA_OUT_BITS'(scaled_cos);
    q_next     = DATA_OUT_BITS'(scaled_sin);
    if (cos_neg_s3) i_next = -DATA_OUT_BITS'(scaled_cos);
    if (sin_neg_s3) q_next = -DATA_OUT_BITS'(scaled_sin);
  end

  // Stage 4: outputs load only with a valid sample and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_ready <= 1'b0;
      data_out_1     <= '0;
      data_out_2     <= '0;
    end else begin
      data_out_ready <= v3;
      if (v3) begin
        data_out_1 <= i_next;
        data_out_2 <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_polar_to_rect.sv
// tb_polar_to_rect: directed vectors with hand-computed I/Q values pushed
// into a scoreboard; an independent monitor pops and compares on every
// output strobe and checks reset values, output hold and strobe timing.
module tb_polar_to_rect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_in_ready = 1'b0;
  logic [16:0] mag_in = '0;
  logic [11:0] phase_in = '0;
  logic [17:0] data_out_1;
  logic [17:0] data_out_2;
  logic        data_out_ready;

  polar_to_rect dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_ready  (data_in_ready),
    .mag_in         (mag_in),
    .phase_in       (phase_in),
    .data_out_1     (data_out_1),
    .data_out_2     (data_out_2),
    .data_out_ready (data_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int exp_i;
    int exp_q;
    int tag;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_i = 0;
  int   last_q = 0;
  int   tag_count = 0;

  // Free-running cycle counter, advanced on every rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s (vec %0d): got %0d, want %0d", name, tag, got, want);
    end
  endtask

  // Drive one accepted sample; its expected output is due 4 cycles later.
  task automatic applyStimulus(input int mag, input int phase, input int ei, input int eq);
    exp_t e;
    @(posedge clk);
    #1;
    data_in_ready = 1'b1;
    mag_in        = 17'(mag);
    phase_in      = 12'(phase);
    e.due   = cycle + 4;
    e.exp_i = ei;
    e.exp_q = eq;
    e.tag   = tag_count;
    tag_count++;
    sb.push_back(e);
  endtask

  // Drive a sample that a later reset must discard: nothing is expected.
  task automatic launchDropped(input int mag, input int phase);
    @(posedge clk);
    #1;
    data_in_ready = 1'b1;
    mag_in        = 17'(mag);
    phase_in      = 12'(phase);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      data_in_ready = 1'b0;
      mag_in        = 17'($urandom);
      phase_in      = 12'($urandom);
    end
  endtask

  // Monitor: reset values, scoreboard compare on strobe, hold when idle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      checkOutput("reset_ready", -1, int'(data_out_ready), 0);
      checkOutput("reset_i", -1, $signed(data_out_1), 0);
      checkOutput("reset_q", -1, $signed(data_out_2), 0);
      last_i = 0;
      last_q = 0;
    end else if (data_out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d, want none", cycle);
      end else begin
        e = sb.pop_front();
        checkOutput("latency", e.tag, cycle, e.due);
        checkOutput("I", e.tag, $signed(data_out_1), e.exp_i);
        checkOutput("Q", e.tag, $signed(data_out_2), e.exp_q);
      end
      last_i = $signed(data_out_1);
      last_q = $signed(data_out_2);
    end else begin
      checkOutput("hold_i", -1, $signed(data_out_1), last_i);
      checkOutput("hold_q", -1, $signed(data_out_2), last_q);
      if (sb.size() != 0 && sb[0].due < cycle) begin
        e = sb.pop_front();
        vectors++;
        miscompares++;
        $display("[TB] FAIL missing_strobe (vec %0d): got no strobe by cycle %0d, want one at %0d",
                 e.tag, cycle, e.due);
      end
    end
  end

  initial begin
    // Reset held with random inputs toggling.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      data_in_ready = 1'($urandom_range(0, 1));
      mag_in        = 17'($urandom);
      phase_in      = 12'($urandom);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    data_in_ready = 1'b0;

    // First sample after release, isolated to see the single-cycle pulse.
    applyStimulus(1000, 0, 999, 0);
    idle(6);

    // Cardinal, diagonal, full-scale and zero-magnitude vectors.
    applyStimulus(1000, 1024, 0, 999);   idle(1);
    applyStimulus(1000, 2048, -999, 0);  idle(1);
    applyStimulus(1000, 3072, 0, -999);  idle(1);
    applyStimulus(1000, 512, 707, 707);  idle(1);
    applyStimulus(1000, 1536, -707, 707); idle(1);
    applyStimulus(1000, 2560, -707, -707); idle(1);
    applyStimulus(1000, 3584, 707, -707); idle(1);
    applyStimulus(131071, 0, 131069, 0); idle(1);
    applyStimulus(131071, 2048, -131069, 0); idle(1);
    applyStimulus(131071, 1024, 0, 131069); idle(1);
    applyStimulus(131071, 3072, 0, -131069); idle(1);
    applyStimulus(0, 700, 0, 0);
    idle(6);

    // Streaming: four back-to-back, two-cycle gap, then one more.
    applyStimulus(1000, 0, 999, 0);
    applyStimulus(1000, 1024, 0, 999);
    applyStimulus(1000, 2048, -999, 0);
    applyStimulus(1000, 3072, 0, -999);
    idle(2);
    applyStimulus(1000, 512, 707, 707);
    idle(8);

    // Mid-flight reset: three samples launched, then reset before any emerges.
    launchDropped(1000, 0);
    launchDropped(1000, 1024);
    launchDropped(1000, 2048);
    @(posedge clk);
    #1;
    data_in_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    applyStimulus(1000, 2048, -999, 0);
    idle(2);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d outstanding, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
